// File: rtl/mult_datapath_if.sv
// Strobe/status bundle between the multiplier control FSM (master) and the
// shift-add datapath (slave).
interface mult_datapath_if #(
    parameter int N = 4
);
    logic           Load;
    logic           Sh;
    logic           Ad;
    logic           Done;
    logic [N-1:0]   Mplier;
    logic [N-1:0]   Mcand;
    logic           K;
    logic           M;
    logic [2*N-1:0] Product;

    modport master (
        output Load, Sh, Ad, Done, Mplier, Mcand,
        input  K, M, Product
    );

    modport slave (
        input  Load, Sh, Ad, Done, Mplier, Mcand,
        output K, M, Product
    );
endinterface

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: (2N+1)-bit accumulator/multiplier register and shift counter.
// Optional MULT_PROD_LATCH_EN: Product held in a register captured on Done.
module mult_datapath #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic         Clk,
    input  logic         Rst,
    mult_datapath_if.slave bus
);
    logic [2*N:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [N:0]    w_sum;
    logic          w_cnt_last;

    // Carry of the add lands in r_acc[2N] and is shifted down on the next Sh.
    assign w_sum      = {1'b0, r_acc[2*N-1:N]} + {1'b0, bus.Mcand};
    assign w_cnt_last = (r_cnt == CW'(N-1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (bus.Load) begin
            r_acc <= {{(N+1){1'b0}}, bus.Mplier};
            r_cnt <= '0;
        end else if (bus.Ad) begin
            r_acc <= {w_sum, r_acc[N-1:0]};
        end else if (bus.Sh) begin
            r_acc <= {1'b0, r_acc[2*N:1]};
            r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign bus.K = w_cnt_last;
    assign bus.M = r_acc[0];

`ifdef MULT_PROD_LATCH_EN
    logic [2*N-1:0] r_prod;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_prod <= '0;
        end else if (bus.Done) begin
            r_prod <= r_acc[2*N-1:0];
        end
    end

    assign bus.Product = r_prod;
`else
    logic w_unused_done;

    assign w_unused_done = bus.Done;
    assign bus.Product   = r_acc[2*N-1:0];
`endif
endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath (N=4): arithmetic reference model,
// per-cycle compare process, and directed plus random multiplications.
module tb_mult_datapath;
    localparam int NB = 4;

    logic Clk;
    logic Rst;
    bit   mon_en;
    int   n_vec;
    int   n_err;

    mult_datapath_if #(.N(NB)) ifc ();

    mult_datapath #(.N(NB)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: accumulator as a plain integer, counter modulo N.
    int m_acc;
    int m_cnt;
    int m_prod;

    always @(posedge Clk or posedge Rst) begin
        int old_acc;
        int upper;
        if (Rst) begin
            m_acc  = 0;
            m_cnt  = 0;
            m_prod = 0;
        end else begin
            old_acc = m_acc;
            if (ifc.Load) begin
                m_acc = int'(ifc.Mplier);
                m_cnt = 0;
            end else if (ifc.Ad) begin
                upper = (m_acc / (2**NB)) % (2**NB) + int'(ifc.Mcand);
                m_acc = upper * (2**NB) + (m_acc % (2**NB));
            end else if (ifc.Sh) begin
                m_acc = m_acc / 2;
                m_cnt = (m_cnt + 1) % NB;
            end
            if (ifc.Done) m_prod = old_acc % (2**(2*NB));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        int exp_prod;
        if (mon_en) begin
`ifdef MULT_PROD_LATCH_EN
            exp_prod = m_prod;
`else
            exp_prod = m_acc % (2**(2*NB));
`endif
            chk("mon_K", 32'(ifc.K), 32'(m_cnt == NB-1));
            chk("mon_M", 32'(ifc.M), 32'(m_acc % 2));
            chk("mon_Product", 32'(ifc.Product), 32'(exp_prod));
        end
    end

    task automatic step(input logic l, input logic s, input logic a, input logic d);
        ifc.Load = l;
        ifc.Sh   = s;
        ifc.Ad   = a;
        ifc.Done = d;
        @(posedge Clk);
        #1;
        ifc.Load = 1'b0;
        ifc.Sh   = 1'b0;
        ifc.Ad   = 1'b0;
        ifc.Done = 1'b0;
    endtask

    // Control-FSM model: Load, N x (add: Ad=M, shift: Sh), Done.
    task automatic run_mult(input logic [NB-1:0] a, input logic [NB-1:0] b,
                            input bit chk_hold, input logic [2*NB-1:0] hold,
                            output logic [2*NB-1:0] prod, output logic [NB-1:0] mseq,
                            output logic [NB-1:0] kseq, output logic carry);
        carry      = 1'b0;
        ifc.Mplier = a;
        ifc.Mcand  = b;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        if (chk_hold) chk("hold_after_load", 32'(ifc.Product), 32'(hold));
        for (int i = 0; i < NB; i++) begin
            mseq[i] = ifc.M;
            step(1'b0, 1'b0, ifc.M, 1'b0);
            carry   = carry | dut.r_acc[2*NB];
            kseq[i] = ifc.K;
            if (chk_hold) chk("hold_after_add", 32'(ifc.Product), 32'(hold));
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (chk_hold) chk("hold_after_shift", 32'(ifc.Product), 32'(hold));
        end
        chk("acc_carry_at_done", 32'(dut.r_acc[2*NB]), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        prod = ifc.Product;
    endtask

    initial begin
        logic [2*NB-1:0] prod;
        logic [NB-1:0]   mseq;
        logic [NB-1:0]   kseq;
        logic            carry;
        logic [NB-1:0]   ra;
        logic [NB-1:0]   rb;

        n_vec = 0;
        n_err = 0;
        mon_en = 1'b0;
        Rst = 1'b1;
        ifc.Load = 1'b0; ifc.Sh = 1'b0; ifc.Ad = 1'b0; ifc.Done = 1'b0;
        ifc.Mplier = '0; ifc.Mcand = '0;
        @(posedge Clk); #1;
        chk("reset_K", 32'(ifc.K), 32'd0);
        chk("reset_M", 32'(ifc.M), 32'd0);
        chk("reset_Product", 32'(ifc.Product), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        mon_en = 1'b1;

        run_mult(4'd11, 4'd13, 1'b0, '0, prod, mseq, kseq, carry);
        chk("11x13_product", 32'(prod), 32'd143);
        chk("11x13_M_seq", 32'(mseq), 32'b1011);
        chk("11x13_K_seq", 32'(kseq), 32'b1000);

        run_mult(4'd15, 4'd15, 1'b0, '0, prod, mseq, kseq, carry);
        chk("15x15_product", 32'(prod), 32'd225);
        chk("15x15_carry_seen", 32'(carry), 32'd1);

        run_mult(4'd0, 4'd9, 1'b0, '0, prod, mseq, kseq, carry);
        chk("0x9_product", 32'(prod), 32'd0);
        chk("0x9_no_add", 32'(mseq), 32'd0);
        chk("0x9_K_seq", 32'(kseq), 32'b1000);

        // Async reset after the second shift of 7*5.
        ifc.Mplier = 4'd7;
        ifc.Mcand  = 4'd5;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, ifc.M, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst_acc", 32'(dut.r_acc), 32'd0);
        chk("async_rst_cnt", 32'(dut.r_cnt), 32'd0);
        chk("async_rst_K", 32'(ifc.K), 32'd0);
        chk("async_rst_M", 32'(ifc.M), 32'd0);
        chk("async_rst_Product", 32'(ifc.Product), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        run_mult(4'd7, 4'd5, 1'b0, '0, prod, mseq, kseq, carry);
        chk("7x5_product", 32'(prod), 32'd35);

        // Strobe priority with a non-zero accumulator.
        ifc.Mplier = 4'd10;
        ifc.Mcand  = 4'd3;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("prio_load_acc", 32'(dut.r_acc), 32'h00A);
        chk("prio_load_cnt", 32'(dut.r_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("prio_add_acc", 32'(dut.r_acc), 32'h03A);
        chk("prio_add_cnt", 32'(dut.r_cnt), 32'd0);

        run_mult(4'd11, 4'd13, 1'b0, '0, prod, mseq, kseq, carry);
        chk("11x13_again", 32'(prod), 32'd143);
`ifdef MULT_PROD_LATCH_EN
        run_mult(4'd6, 4'd3, 1'b1, 8'd143, prod, mseq, kseq, carry);
`else
        run_mult(4'd6, 4'd3, 1'b0, '0, prod, mseq, kseq, carry);
`endif
        chk("6x3_product", 32'(prod), 32'd18);

        for (int t = 0; t < 20; t++) begin
            ra = NB'($urandom_range(0, 2**NB - 1));
            rb = NB'($urandom_range(0, 2**NB - 1));
            run_mult(ra, rb, 1'b0, '0, prod, mseq, kseq, carry);
            chk("rand_product", 32'(prod), 32'(int'(ra) * int'(rb)));
        end

        // Unconstrained strobe mix, including over-shift wraps and Ad+Sh overlap.
        for (int t = 0; t < 60; t++) begin
            ifc.Mplier = NB'($urandom);
            ifc.Mcand  = NB'($urandom);
            step(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
